rpn_engine: RTL
===============

RPN_ENGINE -- requirements
Module: rpn_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits (minimum 4).
REQ-002 SHALL have parameter DEPTH, default 16, operand stack entries (minimum 2).
REQ-003 SHALL have port CLK  input  1  rising-edge clock.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  token offered.
REQ-006 SHALL have port in_data  input  WIDTH  operand value, or opcode in bits [2:0] when in_is_op=1.
REQ-007 SHALL have port in_is_op  input  1  token is an operator.
REQ-008 SHALL have port in_ready  output  1  token accepted when in_valid&in_ready at a rising edge.
REQ-009 SHALL have port out_valid  output  1  result offered.
REQ-010 SHALL have port out_data  output  WIDTH  result value.
REQ-011 SHALL have port out_err  output  3  {div0, underflow, overflow} sticky flags attached to the result.
REQ-012 SHALL have port out_ready  input  1  result consumed when out_valid&out_ready at a rising edge.
REQ-013 SHALL have port depth  output  $clog2(DEPTH+1)  current stack occupancy.

Function
REQ-014 SHALL decode opcodes: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 EQ, 101 MOD, 110 CLR, 111 reserved.
REQ-015 SHALL compute all arithmetic unsigned, modulo 2^WIDTH; MUL keeps the low WIDTH bits; SUB wraps.
REQ-016 SHALL use FSM states IDLE, POP_R, POP_L, EXEC, EMIT; in_ready=1 only in IDLE.
REQ-017 SHALL push an accepted operand on the same edge it is accepted and stay in IDLE (one operand per cycle).
REQ-018 SHALL, for an accepted operand with depth==DEPTH, drop it, leave the stack unchanged, and set sticky overflow.
REQ-019 SHALL, for an accepted binary operator with depth>=2, go IDLE->POP_R->POP_L->EXEC->IDLE; the result is pushed on the EXEC edge and in_ready is low for exactly 3 cycles.
REQ-020 SHALL latch the opcode at acceptance; in_data changes after acceptance do not affect the operation.
REQ-021 SHALL pop right = top first and left = next second; the result is left op right.
REQ-022 SHALL, for a binary operator with depth<2, discard the operator, leave the stack unchanged, set sticky underflow, and stay in IDLE.
REQ-023 SHALL, for DIV with right==0, push all-ones and set sticky div0.
REQ-024 SHALL, for MOD with right==0, push left and set sticky div0.
REQ-025 SHALL, for EQ, pop the top (or output 0 with underflow set if empty), go to EMIT, and assert out_valid with out_data and out_err.
REQ-026 SHALL hold out_data/out_err stable while out_valid=1 and out_ready=0.
REQ-027 SHALL, on the out handshake, deassert out_valid, clear all sticky flags, and return to IDLE in the same edge.
REQ-028 SHALL, for CLR, set depth to 0 and clear the sticky flags in one cycle.
REQ-029 SHALL treat opcode 111 as a no-op that sets sticky underflow.
REQ-030 SHALL keep the stack contents below the result intact after EQ.

Reset
REQ-031 SHALL, while RST=1, force the FSM to IDLE, depth=0, sticky flags=0, out_valid=0, out_data=0, out_err=0, in_ready=0.
REQ-032 SHALL assert in_ready=1 on the first rising edge after RST deasserts.
REQ-033 SHALL discard any in-flight operation or pending result on RST mid-operation, with no push and no output.

Structure
REQ-034 SHALL place the opcode encodings, FSM state encodings and error-bit indices in a shared package rpn_pkg.
REQ-035 SHALL implement storage in one sub-module lifo_stack (parameters WIDTH, DEPTH) with synchronous push/pop, a combinational top read, a count output, and a clear input.
REQ-036 SHALL not infer dividers beyond one shared DIV/MOD unit.

Verification
REQ-037 SHALL cover: 5, 3, ADD, EQ -> out_data=8, out_err=000, depth=0 after the handshake.
REQ-038 SHALL cover: 2, 7, SUB, EQ at WIDTH=8 -> out_data=251 (0xFB), out_err=000.
REQ-039 SHALL cover: 9, 0, DIV, EQ -> out_data=all-ones, out_err=100; then 9, 0, MOD, EQ -> out_data=9, out_err=100.
REQ-040 SHALL cover: DEPTH=4, push 1,2,3,4,5, EQ -> out_data=4, out_err=001, depth=3.
REQ-041 SHALL cover: single operand 6, MUL, EQ -> out_data=6, out_err=010; hold out_ready=0 for 5 cycles -> out_data/out_err held stable.
REQ-042 SHALL cover: assert RST in POP_L during 4, 2, MUL -> depth=0, out_valid=0, in_ready=1 one cycle after release.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared encodings for the RPN calculator: opcodes, controller states and
// the bit positions of the sticky error flags reported with each result.
package rpn_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_EQ  = 3'b100,
        OP_MOD = 3'b101,
        OP_CLR = 3'b110,
        OP_RSV = 3'b111
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP_R = 3'd1,
        POP_L = 3'd2,
        EXEC  = 3'd3,
        EMIT  = 3'd4
    } state_t;

    localparam int ERR_W     = 3;
    localparam int ERR_OVER  = 0;
    localparam int ERR_UNDER = 1;
    localparam int ERR_DIV0  = 2;

    function automatic logic is_binary(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
               (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/rpn_if.sv
// Token-in / result-out handshake bundle of the RPN engine, plus the
// stack occupancy it reports.
interface rpn_if
    import rpn_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    logic                       in_valid;
    logic [WIDTH-1:0]           in_data;
    logic                       in_is_op;
    logic                       in_ready;
    logic                       out_valid;
    logic [WIDTH-1:0]           out_data;
    logic [ERR_W-1:0]           out_err;
    logic                       out_ready;
    logic [$clog2(DEPTH+1)-1:0] depth;

    modport master (
        output in_valid, in_data, in_is_op, out_ready,
        input  in_ready, out_valid, out_data, out_err, depth
    );

    modport slave (
        input  in_valid, in_data, in_is_op, out_ready,
        output in_ready, out_valid, out_data, out_err, depth
    );
endinterface

// File: rtl/lifo_stack.sv
// Operand stack: synchronous push/pop/clear, combinational top-of-stack read.
// Reading an empty stack returns zero.
module lifo_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           top_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    top_idx;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] entries [DEPTH];

    assign full    = (count_reg == FULL);
    assign empty   = (count_reg == '0);
    assign top_idx = count_reg - CW'(1);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;
            always_ff @(posedge CLK) begin
                if (push && !full && !clear && count_reg == CW'(gi)) begin
                    entry_reg <= push_data;
                end
            end
            assign entries[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (push && !full) begin
            count_reg <= count_reg + CW'(1);
        end else if (pop && !empty) begin
            count_reg <= count_reg - CW'(1);
        end
    end

    assign top_data = empty ? '0 : entries[top_idx[AW-1:0]];
    assign count    = count_reg;
endmodule

// File: rtl/rpn_engine.sv
// Reverse-Polish calculator: operands are pushed as they arrive, binary
// operators pop two entries over two cycles and push the result, EQ emits.
module rpn_engine
    import rpn_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic CLK,
    input  logic RST,
    rpn_if.slave bus
);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] TWO  = CW'(2);

    state_t           state_reg, state_next;
    opcode_t          op_reg, op_next;
    logic [WIDTH-1:0] left_reg, left_next;
    logic [WIDTH-1:0] right_reg, right_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic [ERR_W-1:0] flags_reg, flags_next;
    logic [ERR_W-1:0] out_err_reg, out_err_next;
    logic             rst_done_reg;

    logic             st_push, st_pop, st_clear;
    logic [WIDTH-1:0] st_wdata, st_top;
    logic [CW-1:0]    st_count;

    logic [WIDTH-1:0] divisor, quotient, mul_a, product, remainder, alu_result;
    logic             alu_div0;
    opcode_t          in_op;
    logic             accept;

    lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
        .CLK       (CLK),
        .RST       (RST),
        .clear     (st_clear),
        .push      (st_push),
        .pop       (st_pop),
        .push_data (st_wdata),
        .top_data  (st_top),
        .count     (st_count)
    );

    assign in_op  = opcode_t'(bus.in_data[2:0]);
    assign accept = bus.in_valid && bus.in_ready;

    // One divider serves DIV and MOD; the remainder reuses the multiplier.
    // A zero divisor gives product 0, so MOD by zero naturally yields left.
    always_comb begin
        divisor    = (right_reg == '0) ? WIDTH'(1) : right_reg;
        quotient   = left_reg / divisor;
        mul_a      = (op_reg == OP_MOD) ? quotient : left_reg;
        product    = mul_a * right_reg;
        remainder  = left_reg - product;
        alu_div0   = (right_reg == '0) && ((op_reg == OP_DIV) || (op_reg == OP_MOD));
        case (op_reg)
            OP_ADD:  alu_result = left_reg + right_reg;
            OP_SUB:  alu_result = left_reg - right_reg;
            OP_MUL:  alu_result = product;
            OP_DIV:  alu_result = (right_reg == '0) ? '1 : quotient;
            OP_MOD:  alu_result = remainder;
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= IDLE;
            op_reg       <= OP_ADD;
            left_reg     <= '0;
            right_reg    <= '0;
            out_data_reg <= '0;
            flags_reg    <= '0;
            out_err_reg  <= '0;
            rst_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            op_reg       <= op_next;
            left_reg     <= left_next;
            right_reg    <= right_next;
            out_data_reg <= out_data_next;
            flags_reg    <= flags_next;
            out_err_reg  <= out_err_next;
            rst_done_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        left_next     = left_reg;
        right_next    = right_reg;
        out_data_next = out_data_reg;
        flags_next    = flags_reg;
        out_err_next  = out_err_reg;
        st_push       = 1'b0;
        st_pop        = 1'b0;
        st_clear      = 1'b0;
        st_wdata      = bus.in_data;

        case (state_reg)
            IDLE: begin
                if (accept && !bus.in_is_op) begin
                    if (st_count == FULL) flags_next[ERR_OVER] = 1'b1;
                    else                  st_push = 1'b1;
                end else if (accept && is_binary(in_op)) begin
                    if (st_count >= TWO) begin
                        op_next    = in_op;
                        state_next = POP_R;
                    end else begin
                        flags_next[ERR_UNDER] = 1'b1;
                    end
                end else if (accept) begin
                    case (in_op)
                        OP_EQ: begin
                            if (st_count != '0) begin
                                st_pop        = 1'b1;
                                out_data_next = st_top;
                            end else begin
                                out_data_next         = '0;
                                flags_next[ERR_UNDER] = 1'b1;
                            end
                            out_err_next = flags_next;
                            state_next   = EMIT;
                        end
                        OP_CLR: begin
                            st_clear   = 1'b1;
                            flags_next = '0;
                        end
                        default: flags_next[ERR_UNDER] = 1'b1;
                    endcase
                end
            end
            POP_R: begin
                st_pop     = 1'b1;
                right_next = st_top;
                state_next = POP_L;
            end
            POP_L: begin
                st_pop     = 1'b1;
                left_next  = st_top;
                state_next = EXEC;
            end
            EXEC: begin
                st_push  = 1'b1;
                st_wdata = alu_result;
                if (alu_div0) flags_next[ERR_DIV0] = 1'b1;
                state_next = IDLE;
            end
            EMIT: begin
                if (bus.out_ready) begin
                    flags_next = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = rst_done_reg && (state_reg == IDLE);
    assign bus.out_valid = (state_reg == EMIT);
    assign bus.out_data  = out_data_reg;
    assign bus.out_err   = out_err_reg;
    assign bus.depth     = st_count;
endmodule
